spill_buffer_flushable: RTL

SPILL_BUFFER_FLUSHABLE -- requirements
Module: spill_buffer_flushable

---
 rtl/spill_buffer_flushable.sv | 118 +++++++++++
 1 files changed

// File: rtl/spill_buffer_flushable.sv
// Flushable ring-buffer skid stage with registered valid/ready; Bypass=1 is a wire.
// Define SPILL_BUFFER_FLUSH_WRITE_EN to keep a push that coincides with flush_i.
module spill_buffer_flushable #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned Depth     = 2,
  parameter bit          Bypass    = 1'b0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clr_i,
  input  logic                         flush_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [DataWidth-1:0]         data_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [DataWidth-1:0]         data_o,
  output logic [$clog2(Depth+1)-1:0]   usage_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth+1);

  if (Bypass) begin : g_bypass
    assign valid_o = valid_i;
    assign ready_o = ready_i;
    assign data_o  = data_i;
    assign usage_o = '0;

    logic unused_bypass;
    assign unused_bypass = ^{clk_i, rst_i, clr_i, flush_i};
  end else begin : g_buf
    logic [DataWidth-1:0] mem_q [Depth];
    logic [DataWidth-1:0] mem_d [Depth];
    logic [PtrW-1:0]      rptr_q, rptr_d;
    logic [PtrW-1:0]      wptr_q, wptr_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic                 ready_q, ready_d;
    logic                 push, pop;

    function automatic logic [PtrW-1:0] inc(
      input logic [PtrW-1:0] p
    );
      return (p == PtrW'(Depth-1)) ? '0 : p + 1'b1;
    endfunction

    assign push = valid_i && ready_q;
    assign pop  = valid_q && ready_i;

    always_comb begin
      mem_d  = mem_q;
      rptr_d = rptr_q;
      wptr_d = wptr_q;
      cnt_d  = cnt_q;
      if (clr_i) begin
        for (int i = 0; i < Depth; i++) mem_d[i] = '0;
        rptr_d = '0;
        wptr_d = '0;
        cnt_d  = '0;
      end else if (flush_i) begin
        rptr_d = '0;
        wptr_d = '0;
        cnt_d  = '0;
`ifdef SPILL_BUFFER_FLUSH_WRITE_EN
        if (push) begin
          mem_d[0] = data_i;
          wptr_d   = PtrW'(1);
          cnt_d    = CntW'(1);
        end
`endif
      end else begin
        if (push) begin
          mem_d[wptr_q] = data_i;
          wptr_d        = inc(wptr_q);
        end
        if (pop) rptr_d = inc(rptr_q);
        cnt_d = cnt_q + CntW'(push) - CntW'(pop);
      end
      valid_d = (cnt_d != '0);
      ready_d = (cnt_d != CntW'(Depth));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
        rptr_q  <= '0;
        wptr_q  <= '0;
        cnt_q   <= '0;
        valid_q <= 1'b0;
        ready_q <= 1'b1;
      end else begin
        mem_q   <= mem_d;
        rptr_q  <= rptr_d;
        wptr_q  <= wptr_d;
        cnt_q   <= cnt_d;
        valid_q <= valid_d;
        ready_q <= ready_d;
      end
    end

    assign valid_o = valid_q;
    assign ready_o = ready_q;
    assign data_o  = mem_q[rptr_q];
    assign usage_o = cnt_q;

`ifndef SPILL_BUFFER_FLUSH_WRITE_EN
`ifndef SYNTHESIS
    // The beat is acknowledged upstream yet lost; make that visible in sim.
    always_ff @(posedge clk_i) begin
      if (!rst_i && !clr_i && flush_i && push)
        $warning("spill_buffer_flushable: push dropped by flush");
    end
`endif
`endif
  end

endmodule
